activation_lut_loader: RTL and testbench

//  Writer/owner side of the activation-function lookup table. Accepts a stream of
//  2**ADDR_W+1 sample points over a valid/ready load port and stores them in a flop table.

---
 rtl/activation_lut_loader.sv | 126 ++++++++++++
 tb/tb_activation_lut_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/activation_lut_loader.sv
// Activation LUT owner: streams N = 2**ADDR_W+1 samples into a flop table,
// then serves registered (T[a], T[a+1]) lookups for the interpolator.
module activation_lut_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     load_valid,
    input  logic signed [DATA_W-1:0] load_data,
    output logic                     load_ready,
    output logic                     loaded,
    input  logic                     rd_en,
    input  logic        [ADDR_W-1:0] address,
    output logic                     rd_valid,
    output logic                     rd_miss,
    output logic signed [DATA_W-1:0] base,
    output logic signed [DATA_W-1:0] next_data
);

    localparam int N = 2**ADDR_W + 1;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(N - 1);

    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        READY
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] table_q [N];
    logic [DATA_W-1:0] table_d [N];
    logic              rd_valid_q, rd_valid_d;
    logic              rd_miss_q, rd_miss_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] next_q, next_d;
    logic              accept;
    logic [ADDR_W:0]   rd_lo, rd_hi;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        table_d    = table_q;
        load_ready = (state_q == LOADING) && !load_start;
        accept     = load_ready && load_valid;
        unique case (state_q)
            EMPTY: begin
                if (load_start) begin
                    state_d = LOADING;
                    count_d = '0;
                end
            end
            LOADING: begin
                if (load_start) begin
                    count_d = '0;
                end else if (accept) begin
                    table_d[count_q] = load_data;
                    // Final sample: count parks at 0 so it never passes N-1
                    if (count_q == LAST) begin
                        state_d = READY;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            READY: begin
                if (load_start) begin
                    state_d = LOADING;
                    count_d = '0;
                end
            end
            default: begin
                state_d = EMPTY;
                count_d = '0;
            end
        endcase
    end

    assign loaded = (state_q == READY);

    always_comb begin
        rd_lo      = {1'b0, address};
        rd_hi      = rd_lo + 1'b1;
        rd_valid_d = rd_en && loaded;
        rd_miss_d  = rd_en && !loaded;
        base_d     = base_q;
        next_d     = next_q;
        if (rd_valid_d) begin
            base_d = table_q[rd_lo];
            next_d = table_q[rd_hi];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_miss_q  <= 1'b0;
            base_q     <= '0;
            next_q     <= '0;
            for (int i = 0; i < N; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_miss_q  <= rd_miss_d;
            base_q     <= base_d;
            next_q     <= next_d;
            for (int i = 0; i < N; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_miss   = rd_miss_q;
    assign base      = base_q;
    assign next_data = next_q;

endmodule

// File: tb/tb_activation_lut_loader.sv
// Bench for activation_lut_loader: directed scenarios with random data,
// checked against a queue-based model of the load/lookup rules.
module tb_activation_lut_loader;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int N  = 2**AW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_ready;
    logic          loaded;
    logic          rd_en = 1'b0;
    logic [AW-1:0] address = '0;
    logic          rd_valid;
    logic          rd_miss;
    logic [DW-1:0] base;
    logic [DW-1:0] next_data;

    activation_lut_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .loaded     (loaded),
        .rd_en      (rd_en),
        .address    (address),
        .rd_valid   (rd_valid),
        .rd_miss    (rd_miss),
        .base       (base),
        .next_data  (next_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mt [N];
    logic [DW-1:0] q [$];
    bit            m_loading = 1'b0;
    bit            m_loaded  = 1'b0;
    logic [DW-1:0] eb = '0;
    logic [DW-1:0] en = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mt[i] = '0;
        q.delete();
        m_loading = 1'b0;
        m_loaded  = 1'b0;
        eb = '0;
        en = '0;
    endtask

    task automatic cyc(input bit ls, input bit lv, input logic [DW-1:0] ld,
                       input bit re, input logic [AW-1:0] a);
        bit erv;
        bit erm;
        load_start = ls;
        load_valid = lv;
        load_data  = ld;
        rd_en      = re;
        address    = a;
        #1;
        chk("load_ready", {31'b0, load_ready}, {31'b0, m_loading && !ls});
        erv = re && m_loaded;
        erm = re && !m_loaded;
        if (erv) begin
            eb = mt[int'(a)];
            en = mt[int'(a) + 1];
        end
        if (ls) begin
            m_loading = 1'b1;
            m_loaded  = 1'b0;
            q.delete();
        end else if (m_loading && lv) begin
            q.push_back(ld);
            if (q.size() == N) begin
                for (int i = 0; i < N; i++) mt[i] = q[i];
                m_loaded  = 1'b1;
                m_loading = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("rd_valid", {31'b0, rd_valid}, {31'b0, erv});
        chk("rd_miss", {31'b0, rd_miss}, {31'b0, erm});
        chk("base", {24'b0, base}, {24'b0, eb});
        chk("next_data", {24'b0, next_data}, {24'b0, en});
        chk("loaded", {31'b0, loaded}, {31'b0, m_loaded});
        load_start = 1'b0;
        load_valid = 1'b0;
        rd_en      = 1'b0;
    endtask

    // Drive until n samples are accepted; optional gaps and random misses.
    task automatic feed(input int n, input bit gaps, input bit ramp);
        int acc;
        int guard;
        bit lv;
        logic [DW-1:0] d;
        acc = 0;
        guard = 0;
        while (acc < n && guard < 400) begin
            lv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            d  = ramp ? DW'(acc * 8 - 64) : DW'($urandom);
            if (lv && m_loading) acc++;
            cyc(1'b0, lv, d, 1'($urandom_range(0, 1)), AW'($urandom));
            guard++;
        end
        chk("feed_accepts", acc, n);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #12;
        chk("rst_load_ready", {31'b0, load_ready}, 0);
        chk("rst_loaded", {31'b0, loaded}, 0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 0);
        chk("rst_rd_miss", {31'b0, rd_miss}, 0);
        chk("rst_base", {24'b0, base}, 0);
        chk("rst_next", {24'b0, next_data}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Lookup on empty table
        cyc(1'b0, 1'b0, '0, 1'b1, 4'd3);
        chk("empty_miss", {31'b0, rd_miss}, 1);

        // Ramp load with valid held high
        cyc(1'b1, 1'b0, '0, 1'b0, '0);
        feed(N, 1'b0, 1'b1);
        chk("ramp_loaded", {31'b0, loaded}, 1);
        cyc(1'b0, 1'b1, 8'h11, 1'b0, '0);

        cyc(1'b0, 1'b0, '0, 1'b1, 4'd0);
        chk("a0_base", {24'b0, base}, 32'hC0);
        chk("a0_next", {24'b0, next_data}, 32'hC8);
        cyc(1'b0, 1'b0, '0, 1'b1, 4'd15);
        chk("a15_base", {24'b0, base}, 32'h38);
        chk("a15_next", {24'b0, next_data}, 32'h40);
        cyc(1'b0, 1'b0, '0, 1'b1, 4'd5);
        cyc(1'b0, 1'b0, '0, 1'b1, 4'd6);
        cyc(1'b0, 1'b0, '0, 1'b1, 4'd7);

        // Stalled load, restarted after 9 accepts
        cyc(1'b1, 1'b0, '0, 1'b0, '0);
        feed(9, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 8'h5A, 1'b0, '0);
        feed(N, 1'b1, 1'b0);
        for (int a = 0; a < 16; a++) begin
            cyc(1'b0, 1'b0, '0, 1'b1, AW'(a));
        end

        // Read and load_start collide in READY
        cyc(1'b1, 1'b0, '0, 1'b1, 4'd2);
        chk("collide_valid", {31'b0, rd_valid}, 1);
        chk("collide_loaded", {31'b0, loaded}, 0);
        cyc(1'b0, 1'b0, '0, 1'b1, 4'd2);
        chk("collide_miss", {31'b0, rd_miss}, 1);

        // Async reset mid-load
        feed(10, 1'b0, 1'b0);
        load_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_load_ready", {31'b0, load_ready}, 0);
        chk("arst_loaded", {31'b0, loaded}, 0);
        chk("arst_rd_valid", {31'b0, rd_valid}, 0);
        chk("arst_base", {24'b0, base}, 0);
        chk("arst_next", {24'b0, next_data}, 0);
        @(negedge clk);
        rst = 1'b0;
        load_valid = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b1, 8'h33, 1'b1, 4'd7);
        chk("post_rst_miss", {31'b0, rd_miss}, 1);

        cyc(1'b1, 1'b0, '0, 1'b0, '0);
        feed(N, 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), DW'($urandom),
                1'($urandom_range(0, 3) != 0), AW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
